// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : round-robin arbiter/sequencer sharing one memory port
//                   between cache A and cache B, with sticky error reporting.
//                   Optional WAIT timeout enabled by macro MEMBUS_TIMEOUT_EN.
// Revision        : 1.0
// ============================================================================
module mem_bus_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int WORD_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        rwFromCacheA,
   input  logic [ADDR_W-1:0] addrFromCacheA,
   input  logic [WORD_W-1:0] dataFromCacheA,
   output logic [WORD_W-1:0] dataToCacheA,
   output logic              grantToCacheA,
   output logic              doneToCacheA,
   input  logic [1:0]        rwFromCacheB,
   input  logic [ADDR_W-1:0] addrFromCacheB,
   input  logic [WORD_W-1:0] dataFromCacheB,
   output logic [WORD_W-1:0] dataToCacheB,
   output logic              grantToCacheB,
   output logic              doneToCacheB,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [WORD_W-1:0] memWdata,
   input  logic [WORD_W-1:0] memRdata,
   input  logic              memAck,
   output logic [1:0]        errReg
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] c_RW_RD   = 2'd1;
   localparam logic [1:0] c_RW_WT   = 2'd2;
   localparam logic [1:0] c_RW_BAD  = 2'd3;
   localparam logic [1:0] c_ERR_CMD = 2'd2;
   localparam logic [1:0] c_ERR_ACK = 2'd3;

   state_t r_state;
   logic   r_ownerB;   // 1 = cache B owns the current transaction
   logic   r_lastB;    // 1 = cache B was served last
   logic   r_isWr;

`ifdef MEMBUS_TIMEOUT_EN
   localparam logic [1:0] c_ERR_TO  = 2'd1;
   localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] r_toCnt;
`endif

   logic              w_reqA, w_reqB, w_badCmd, w_selB;
   logic [1:0]        w_selRw;
   logic [ADDR_W-1:0] w_selAddr;
   logic [WORD_W-1:0] w_selData;

   assign w_reqA    = (rwFromCacheA == c_RW_RD) || (rwFromCacheA == c_RW_WT);
   assign w_reqB    = (rwFromCacheB == c_RW_RD) || (rwFromCacheB == c_RW_WT);
   assign w_badCmd  = (rwFromCacheA == c_RW_BAD) || (rwFromCacheB == c_RW_BAD);
   // On a tie the cache that was not served last wins
   assign w_selB    = w_reqB && (!w_reqA || !r_lastB);
   assign w_selRw   = w_selB ? rwFromCacheB   : rwFromCacheA;
   assign w_selAddr = w_selB ? addrFromCacheB : addrFromCacheA;
   assign w_selData = w_selB ? dataFromCacheB : dataFromCacheA;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ownerB      <= 1'b0;
         r_lastB       <= 1'b1;
         r_isWr        <= 1'b0;
         memReq        <= 1'b0;
         memWe         <= 1'b0;
         memAddr       <= '0;
         memWdata      <= '0;
         grantToCacheA <= 1'b0;
         grantToCacheB <= 1'b0;
         doneToCacheA  <= 1'b0;
         doneToCacheB  <= 1'b0;
         dataToCacheA  <= '0;
         dataToCacheB  <= '0;
         errReg        <= '0;
`ifdef MEMBUS_TIMEOUT_EN
         r_toCnt       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_badCmd) errReg <= c_ERR_CMD;
               if (memAck)   errReg <= c_ERR_ACK;
               if (w_reqA || w_reqB) begin
                  r_ownerB      <= w_selB;
                  r_isWr        <= (w_selRw == c_RW_WT);
                  memWe         <= (w_selRw == c_RW_WT);
                  memAddr       <= w_selAddr;
                  memWdata      <= w_selData;
                  memReq        <= 1'b1;
                  grantToCacheA <= !w_selB;
                  grantToCacheB <= w_selB;
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               memReq  <= 1'b0;
               memWe   <= 1'b0;
               if (memAck) errReg <= c_ERR_ACK;
`ifdef MEMBUS_TIMEOUT_EN
               r_toCnt <= '0;
`endif
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (memAck) begin
                  if (!r_isWr) begin
                     if (r_ownerB) dataToCacheB <= memRdata;
                     else          dataToCacheA <= memRdata;
                  end
                  r_lastB      <= r_ownerB;
                  doneToCacheA <= !r_ownerB;
                  doneToCacheB <= r_ownerB;
                  r_state      <= S_DONE;
               end
`ifdef MEMBUS_TIMEOUT_EN
               // Abort on the TIMEOUT-th consecutive WAIT cycle without an ack
               else if (r_toCnt == c_TO_LAST) begin
                  if (!r_isWr) begin
                     if (r_ownerB) dataToCacheB <= '1;
                     else          dataToCacheA <= '1;
                  end
                  errReg       <= c_ERR_TO;
                  r_lastB      <= r_ownerB;
                  doneToCacheA <= !r_ownerB;
                  doneToCacheB <= r_ownerB;
                  r_state      <= S_DONE;
               end else begin
                  r_toCnt <= r_toCnt + 8'd1;
               end
`endif
            end
            S_DONE: begin
               if (memAck) errReg <= c_ERR_ACK;
               doneToCacheA  <= 1'b0;
               doneToCacheB  <= 1'b0;
               grantToCacheA <= 1'b0;
               grantToCacheB <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : randomized self-checking bench; a transaction-level
//                      model predicts grant order, memory commands and data.
// Revision           : 1.0
// ============================================================================
module tb_mem_bus_arbiter;
   localparam int AW = 16;
   localparam int WW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    rwA = '0, rwB = '0;
   logic [AW-1:0] addrA = '0, addrB = '0;
   logic [WW-1:0] wdA = '0, wdB = '0;
   logic [WW-1:0] dataToA, dataToB;
   logic          grantA, grantB, doneA, doneB;
   logic          memReq, memWe;
   logic [AW-1:0] memAddr;
   logic [WW-1:0] memWdata;
   logic [WW-1:0] memRdata = '0;
   logic          memAck = 1'b0;
   logic [1:0]    errReg;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .WORD_W(WW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .rwFromCacheA(rwA), .addrFromCacheA(addrA), .dataFromCacheA(wdA),
      .dataToCacheA(dataToA), .grantToCacheA(grantA), .doneToCacheA(doneA),
      .rwFromCacheB(rwB), .addrFromCacheB(addrB), .dataFromCacheB(wdB),
      .dataToCacheB(dataToB), .grantToCacheB(grantB), .doneToCacheB(doneB),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memAck(memAck), .errReg(errReg)
   );

   int n_tests = 0, n_fail = 0, cyc = 0;
   logic [15:0] mem [256];

   // cache agents
   bit          act[2];
   logic [1:0]  cur_rw[2];
   logic [15:0] cur_addr[2], cur_data[2];
   int          remaining[2], done_cyc[2];
   int          start_pct = 0;
   bit          force_b3 = 0, resp_en = 1;
   bit          prev_req[2];

   // transaction model
   bit          own_v = 0, own = 0, own_wr = 0, acked = 0, last_srv = 1, idle_prev = 1;
   int          req_cyc = -100, ack_cyc = -100, rsp_cnt = 0, dly_min = 1, dly_max = 1, n_done = 0;
   logic [15:0] exp_rd = '0;
   logic [15:0] exp_data[2];
   bit          order_q[$];

   task automatic drive_pins();
      for (int c = 0; c < 2; c++) prev_req[c] = act[c];
      rwA   = act[0] ? cur_rw[0] : 2'd0;
      rwB   = force_b3 ? 2'd3 : (act[1] ? cur_rw[1] : 2'd0);
      addrA = cur_addr[0]; addrB = cur_addr[1];
      wdA   = cur_data[0]; wdB   = cur_data[1];
   endtask

   task automatic req(input int c, input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
      act[c] = 1; cur_rw[c] = rw; cur_addr[c] = a; cur_data[c] = d;
      drive_pins();
   endtask

   task automatic tick();
      bit w, any_done, to_hit, eg, ed, exp_req;
      logic g, dn;
      logic [15:0] dt;
      @(posedge clk); #1;
      cyc++;
      exp_req = idle_prev && (prev_req[0] || prev_req[1]);
      n_tests++;
      if (memReq !== exp_req) begin
         n_fail++; $display("FAIL memReq cyc=%0d got=%b exp=%b", cyc, memReq, exp_req);
      end
      if (exp_req && memReq === 1'b1) begin
         w = (prev_req[0] && prev_req[1]) ? !last_srv : prev_req[1];
         own_v = 1; own = w; own_wr = (cur_rw[w] == 2'd2); acked = 0; req_cyc = cyc;
         order_q.push_back(w);
         n_tests++;
         if (memWe !== own_wr || memAddr !== cur_addr[w] || (own_wr && memWdata !== cur_data[w])) begin
            n_fail++;
            $display("FAIL issue cyc=%0d got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h",
                     cyc, memWe, memAddr, memWdata, own_wr, cur_addr[w], cur_data[w]);
         end
         if (own_wr) mem[cur_addr[w][7:0]] = cur_data[w];
         exp_rd  = mem[cur_addr[w][7:0]];
         rsp_cnt = int'($urandom_range(dly_max, dly_min));
      end
`ifdef MEMBUS_TIMEOUT_EN
      to_hit = own_v && !acked && (cyc == req_cyc + 1 + TO);
`else
      to_hit = 1'b0;
`endif
      any_done = 0;
      for (int c = 0; c < 2; c++) begin
         eg = own_v && (int'(own) == c);
         ed = eg && ((acked && cyc == ack_cyc + 1) || to_hit);
         if (ed) begin
            if (!own_wr) exp_data[c] = to_hit ? 16'hFFFF : exp_rd;
            done_cyc[c] = cyc; last_srv = (c == 1); any_done = 1; n_done++;
         end
         g  = (c == 0) ? grantA  : grantB;
         dn = (c == 0) ? doneA   : doneB;
         dt = (c == 0) ? dataToA : dataToB;
         n_tests++;
         if (g !== eg) begin
            n_fail++; $display("FAIL grant%s cyc=%0d got=%b exp=%b", c ? "B" : "A", cyc, g, eg);
         end
         n_tests++;
         if (dn !== ed) begin
            n_fail++; $display("FAIL done%s cyc=%0d got=%b exp=%b", c ? "B" : "A", cyc, dn, ed);
         end
         n_tests++;
         if (dt !== exp_data[c]) begin
            n_fail++; $display("FAIL dataTo%s cyc=%0d got=%h exp=%h", c ? "B" : "A", cyc, dt, exp_data[c]);
         end
      end
      if (any_done) own_v = 0;
      idle_prev = !own_v && !any_done;

      // memory responder
      memAck = 1'b0; memRdata = 16'($urandom);
      if (rsp_cnt > 0 && req_cyc != cyc) begin
         rsp_cnt--;
         if (rsp_cnt == 0 && resp_en) begin
            memAck = 1'b1; memRdata = exp_rd; acked = 1; ack_cyc = cyc;
         end
      end
      // agents hold until the cycle after done, then idle or start anew
      for (int c = 0; c < 2; c++) begin
         if (act[c] && done_cyc[c] == cyc - 1) act[c] = 0;
         if (!act[c] && remaining[c] > 0 && int'($urandom_range(99, 0)) < start_pct) begin
            act[c] = 1; remaining[c]--;
            cur_rw[c]   = 2'($urandom_range(2, 1));
            cur_addr[c] = 16'($urandom_range(255, 0));
            cur_data[c] = 16'($urandom);
         end
      end
      drive_pins();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         act[c] = 0; remaining[c] = 0; done_cyc[c] = -10; exp_data[c] = '0;
      end
      own_v = 0; acked = 0; rsp_cnt = 0; last_srv = 1; force_b3 = 0;
      start_pct = 0; resp_en = 1; memAck = 1'b0;
      drive_pins();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((act[0] || act[1] || remaining[0] > 0 || remaining[1] > 0 || own_v) && n < budget) begin
         tick(); n++;
      end
      n_tests++;
      if (act[0] || act[1] || remaining[0] > 0 || remaining[1] > 0 || own_v) begin
         n_fail++; $display("FAIL wait_idle cyc=%0d got=busy exp=idle within %0d cycles", cyc, budget);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({memReq, memWe, grantA, grantB, doneA, doneB, memAddr, memWdata, dataToA, dataToB, errReg} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got req=%b we=%b gA=%b gB=%b dA=%b dB=%b addr=%h wd=%h dtA=%h dtB=%h err=%0d exp all 0",
                  memReq, memWe, grantA, grantB, doneA, doneB, memAddr, memWdata, dataToA, dataToB, errReg);
      end
   endtask

   task automatic test_single_read();
      int base;
      do_reset();
      mem[8'h10] = 16'hBEEF; dly_min = 100; dly_max = 100;
      base = cyc;
      req(0, 2'd1, 16'h0010, 16'h0);
      wait_idle(300);
      n_tests++;
      if (req_cyc !== base + 1) begin n_fail++; $display("FAIL rd_req_cycle got=%0d exp=%0d", req_cyc - base, 1); end
      n_tests++;
      if (done_cyc[0] !== base + 102) begin n_fail++; $display("FAIL rd_done_cycle got=%0d exp=%0d", done_cyc[0] - base, 102); end
      n_tests++;
      if (dataToA !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=BEEF", dataToA); end
      n_tests++;
      if (done_cyc[1] !== -10) begin n_fail++; $display("FAIL rd_doneB got=cycle %0d exp=never", done_cyc[1]); end
      n_tests++;
      if (errReg !== 2'd0) begin n_fail++; $display("FAIL rd_err got=%0d exp=0", errReg); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dly_min = 2; dly_max = 2; start_pct = 100;
      remaining[0] = 3; remaining[1] = 3;
      order_q.delete();
      req(0, 2'd2, 16'h0004, 16'h1234);
      req(1, 2'd1, 16'h0008, 16'h0);
      wait_idle(200);
      n_tests++;
      if (order_q.size() != 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", order_q.size()); end
      for (int i = 0; i < order_q.size(); i++) begin
         n_tests++;
         if (order_q[i] !== (i % 2 == 1)) begin
            n_fail++; $display("FAIL b2b_order idx=%0d got=%s exp=%s", i, order_q[i] ? "B" : "A", (i % 2) ? "B" : "A");
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      dly_min = 50; dly_max = 50;
      req(0, 2'd1, 16'h0020, 16'h0);
      while (!own_v && n < 5) begin tick(); n++; end
      while (cyc < req_cyc + 5 && n < 20) begin tick(); n++; end
      do_reset();
      n_tests++;
      if (memReq !== 1'b0 || grantA !== 1'b0 || doneA !== 1'b0) begin
         n_fail++; $display("FAIL midreset got req=%b gA=%b dA=%b exp 0 0 0", memReq, grantA, doneA);
      end
      repeat (10) tick();
      dly_min = 1; dly_max = 3;
      order_q.delete();
      req(0, 2'd1, 16'h0031, 16'h0);
      req(1, 2'd2, 16'h0032, 16'h5A5A);
      wait_idle(50);
      n_tests++;
      if (order_q.size() == 0 || order_q[0] !== 1'b0) begin
         n_fail++; $display("FAIL midreset_tie got size=%0d first=%b exp first=A(0)", order_q.size(), order_q.size() ? order_q[0] : 1'b1);
      end
   endtask

   task automatic test_bad_cmd();
      do_reset();
      force_b3 = 1; drive_pins();
      repeat (5) tick();
      n_tests++;
      if (errReg !== 2'd2) begin n_fail++; $display("FAIL badcmd_err got=%0d exp=2", errReg); end
      force_b3 = 0; drive_pins();
      repeat (4) tick();
      n_tests++;
      if (errReg !== 2'd2) begin n_fail++; $display("FAIL badcmd_sticky got=%0d exp=2", errReg); end
      do_reset();
      n_tests++;
      if (errReg !== 2'd0) begin n_fail++; $display("FAIL badcmd_clear got=%0d exp=0", errReg); end
   endtask

   task automatic test_spurious();
      do_reset();
      memAck = 1'b1;
      tick(); tick();
      n_tests++;
      if (errReg !== 2'd3) begin n_fail++; $display("FAIL spurious_err got=%0d exp=3", errReg); end
      dly_min = 1; dly_max = 2;
      order_q.delete();
      req(1, 2'd1, 16'h0040, 16'h0);
      wait_idle(30);
      n_tests++;
      if (order_q.size() != 1 || errReg !== 2'd3) begin
         n_fail++; $display("FAIL spurious_after got n=%0d err=%0d exp n=1 err=3", order_q.size(), errReg);
      end
   endtask

   task automatic test_random();
      int d0;
      do_reset();
      dly_min = 1; dly_max = 4; start_pct = 40;
      remaining[0] = 30; remaining[1] = 30;
      d0 = n_done;
      wait_idle(3000);
      n_tests++;
      if (n_done - d0 != 60) begin n_fail++; $display("FAIL random_count got=%0d exp=60", n_done - d0); end
      n_tests++;
      if (errReg !== 2'd0) begin n_fail++; $display("FAIL random_err got=%0d exp=0", errReg); end
   endtask

`ifdef MEMBUS_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      resp_en = 0; dly_min = 1; dly_max = 1;
      req(0, 2'd1, 16'h0050, 16'h0);
      wait_idle(40);
      n_tests++;
      if (done_cyc[0] - req_cyc !== 1 + TO) begin
         n_fail++; $display("FAIL to_latency got=%0d exp=%0d", done_cyc[0] - req_cyc, 1 + TO);
      end
      n_tests++;
      if (dataToA !== 16'hFFFF || errReg !== 2'd1) begin
         n_fail++; $display("FAIL to_result got data=%h err=%0d exp data=FFFF err=1", dataToA, errReg);
      end
      memAck = 1'b1;
      tick(); tick();
      n_tests++;
      if (errReg !== 2'd3) begin n_fail++; $display("FAIL to_late_ack got=%0d exp=3", errReg); end
      resp_en = 1;
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      for (int c = 0; c < 2; c++) begin
         cur_rw[c] = '0; cur_addr[c] = '0; cur_data[c] = '0; exp_data[c] = '0;
         act[c] = 0; prev_req[c] = 0; remaining[c] = 0; done_cyc[c] = -10;
      end
      test_reset();
      test_single_read();
      test_back_to_back();
      test_reset_mid();
      test_bad_cmd();
      test_spurious();
      test_random();
`ifdef MEMBUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=still running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares the single main-memory port between cache A and cache B.
- Sits between the two cache controllers and the memory model.
- Latches one request at a time, issues a single-cycle memory command, waits for the memory acknowledge, then returns read data and a one-cycle done pulse to the owning cache.
- Reports sticky error codes.

Parameters:
- ADDR_W, 16, memory word-address width.
- WORD_W, 16, data word width.
- TIMEOUT, 255, maximum WAIT cycles before abort (used only with MEMBUS_TIMEOUT_EN); legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rwFromCacheA  in  2  cache A command: 0 IDEL, 1 RD, 2 WT, 3 reserved.
- addrFromCacheA  in  ADDR_W  cache A word address.
- dataFromCacheA  in  WORD_W  cache A write data.
- dataToCacheA  out  WORD_W  read data returned to cache A.
- grantToCacheA  out  1  cache A owns the memory port.
- doneToCacheA  out  1  one-cycle completion pulse to cache A.
- rwFromCacheB, addrFromCacheB, dataFromCacheB, dataToCacheB, grantToCacheB, doneToCacheB: same as the A ports, for cache B.
- memReq  out  1  one-cycle command strobe to memory.
- memWe  out  1  1 = write, 0 = read; valid while memReq is high.
- memAddr  out  ADDR_W  latched address.
- memWdata  out  WORD_W  latched write data.
- memRdata  in  WORD_W  read data; valid in the memAck cycle.
- memAck  in  1  one-cycle completion from memory; never in the same cycle as memReq.
- errReg  out  2  sticky error: 0 none, 1 timeout, 2 bad command, 3 spurious ack.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. All outputs registered.
- Reset (any state, mid-transaction included):
  - state = IDLE.
  - memReq, memWe, grants, dones = 0; memAddr, memWdata, dataTo* = 0; errReg = 0.
  - lastGrant = B, so A wins the first tie.
  - In-flight transaction dropped; no done pulse.
- IDLE: sample both rw inputs.
  - Only one is RD/WT: that cache is selected.
  - Both are RD/WT: the cache other than lastGrant is selected.
  - On selection: latch owner, rw, addr, wdata; set owner's grant; go to ISSUE.
  - rw = 3 on either port: that port is treated as IDEL and errReg is set to 2.
- ISSUE: memReq = 1 for exactly this cycle; memWe = (rw == WT); memAddr/memWdata = latched values. Next state WAIT.
- WAIT: hold until memAck.
  - On memAck with a read: capture memRdata into the owner's dataTo*.
  - On memAck with a write: owner's dataTo* is unchanged.
  - lastGrant = owner; go to DONE.
- DONE: owner's done = 1 for this cycle only; grant drops at the exit edge; next state IDLE.
- Requester rule: rw must be held stable from request until done is seen. In the cycle after done, rw must be IDEL or a new request. IDLE samples that cycle, so a stale command is never re-granted.
- Latency:
  - Request visible in cycle 0 → memReq in cycle 1.
  - memAck in cycle k (k ≥ 2) → done in cycle k+1.
  - Next grant decision in cycle k+2.
  - Minimum 4 cycles per transaction.
- Non-owner: grant = 0 and done = 0 throughout; its dataTo* holds its last value.
- Fairness: two continuously requesting caches alternate strictly A, B, A, B.
- Spurious ack: memAck in IDLE, ISSUE or DONE is ignored and errReg is set to 3.
- errReg: holds the most recent error code until reset.
- Request inputs are not sampled outside IDLE.

Optional Feature:
- Macro: MEMBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without memAck.
  - When it reaches TIMEOUT, the transaction aborts: a read returns all-ones in dataTo*, errReg = 1, and the state goes to DONE (done pulse issued), with lastGrant updated.
  - A memAck arriving later is treated as spurious.
- Undefined: no counter; WAIT persists indefinitely; errReg code 1 never produced.

Test Plan:
- Reset; A RD addr 0x0010 at cycle 0; memAck with memRdata = 0xBEEF at cycle 101 → memReq = 1, memWe = 0, memAddr = 0x0010 only in cycle 1; doneToCacheA in cycle 102; dataToCacheA = 0xBEEF; doneToCacheB never set; errReg = 0.
- A WT addr 0x0004 data 0x1234 and B RD addr 0x0008 simultaneously, both held, memory acks 2 cycles after each memReq → A served first (memWe = 1, memWdata = 0x1234), then B. Four back-to-back rounds with both held: grant order A, B, A, B.
- A RD issued, reset asserted in cycle 5 of WAIT → next cycle state IDLE, memReq = 0, grantToCacheA = 0, no doneToCacheA; first tie after reset goes to A.
- B drives rw = 3, A idle → no memReq, no grant, errReg = 2 held until reset.
- memAck pulsed while IDLE → errReg = 3; no done pulse; state stays IDLE.
- With MEMBUS_TIMEOUT_EN and TIMEOUT = 8: A RD, memAck never asserted → doneToCacheA 8 WAIT cycles after entry; dataToCacheA = 0xFFFF; errReg = 1. A late memAck then sets errReg = 3.
